// File: rtl/if_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_queue_if
//  Purpose  : Bundles the fetch-queue signals: the instruction-memory request
//             channel, the BTB lookup, the EX redirect, and the ID-side
//             dequeue port.
//  Modports : master - the fetch queue (drives imem request and deq_* outputs)
//             slave  - the environment (memory, BTB, EX, ID)
//  Ports    : imem_read_o/imem_addr_o/imem_rdata_i/imem_resp_i  memory request
//             pred_taken_i/pred_target_i                        BTB lookup
//             redirect_i/redirect_pc_i                          EX restart
//             deq_ready_i/deq_valid_o/deq_pc_o/deq_instr_o/
//             deq_pred_taken_o/deq_next_pc_o                    queue head
//             count_o                                           occupancy
//  Revision : 1.0  initial release
// ============================================================================
interface if_fetch_queue_if #(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 4,
  parameter int CW     = $clog2(QDEPTH + 1)
) ();

  logic            imem_read_o;
  logic [XLEN-1:0] imem_addr_o;
  logic [31:0]     imem_rdata_i;
  logic            imem_resp_i;

  logic            pred_taken_i;
  logic [XLEN-1:0] pred_target_i;

  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;

  logic            deq_ready_i;
  logic            deq_valid_o;
  logic [XLEN-1:0] deq_pc_o;
  logic [31:0]     deq_instr_o;
  logic            deq_pred_taken_o;
  logic [XLEN-1:0] deq_next_pc_o;
  logic [CW-1:0]   count_o;

  modport master (
    output imem_read_o,
    output imem_addr_o,
    input  imem_rdata_i,
    input  imem_resp_i,
    input  pred_taken_i,
    input  pred_target_i,
    input  redirect_i,
    input  redirect_pc_i,
    input  deq_ready_i,
    output deq_valid_o,
    output deq_pc_o,
    output deq_instr_o,
    output deq_pred_taken_o,
    output deq_next_pc_o,
    output count_o
  );

  modport slave (
    input  imem_read_o,
    input  imem_addr_o,
    output imem_rdata_i,
    output imem_resp_i,
    output pred_taken_i,
    output pred_target_i,
    output redirect_i,
    output redirect_pc_i,
    output deq_ready_i,
    input  deq_valid_o,
    input  deq_pc_o,
    input  deq_instr_o,
    input  deq_pred_taken_o,
    input  deq_next_pc_o,
    input  count_o
  );

endinterface
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_queue
//  Purpose  : Instruction fetch stage with BTB-steered next PC and a
//             QDEPTH-entry first-word-fall-through queue in front of ID.
//             One memory request is outstanding at a time; the request is
//             held until the one-cycle response strobe. EX redirects flush
//             the queue and squash any fetch still in flight.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous, active-low reset
//             bus  - if_fetch_queue_if.master (memory, BTB, redirect, dequeue)
//  Revision : 1.0  initial release
// ============================================================================
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0060,
  parameter int              CW       = $clog2(QDEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  if_fetch_queue_if.master bus
);

  localparam int              c_ptr_w     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [XLEN-1:0] c_addr_mask = ~XLEN'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,   // ready to issue the next fetch
    S_WAIT = 2'd1,   // fetch outstanding, result will be queued
    S_DROP = 2'd2    // fetch outstanding but squashed by a redirect
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   w_pc_nxt;
  logic [XLEN-1:0]   r_redir_pc;
  logic [XLEN-1:0]   w_redir_pc_nxt;
  logic              r_pred_taken;
  logic [XLEN-1:0]   r_pred_target;

  logic [XLEN-1:0]   r_q_pc     [QDEPTH];
  logic [31:0]       r_q_instr  [QDEPTH];
  logic              r_q_pred   [QDEPTH];
  logic [XLEN-1:0]   r_q_next   [QDEPTH];
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [CW-1:0]     r_count;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic              w_read_req;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic [XLEN-1:0]   w_seq_pc;
  logic [XLEN-1:0]   w_next_pc;
  logic [XLEN-1:0]   w_redir_aligned;

  // pc+4 wraps naturally at XLEN bits.
  assign w_seq_pc        = r_pc + XLEN'(4);
  // The prediction captured at issue decides where the fetch stream goes next.
  assign w_next_pc       = r_pred_taken ? r_pred_target : w_seq_pc;
  assign w_redir_aligned = bus.redirect_pc_i & c_addr_mask;
  assign w_full          = (r_count == CW'(QDEPTH));

  // A redirect kills the whole queue, so an ID handshake in that cycle is
  // meaningless and must not move the head pointer.
  assign w_pop = (r_count != '0) && bus.deq_ready_i && !bus.redirect_i;

  function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(QDEPTH - 1)) ? '0 : p + c_ptr_w'(1);
  endfunction

  // --------------------------------------------------------------------------
  // FSM: next state, next PC and request strobe
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_redir_pc_nxt = r_redir_pc;
    w_read_req     = 1'b0;
    w_issue        = 1'b0;
    w_push         = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Issue is suppressed while the queue is full, which together with a
        // single outstanding request guarantees the push can never overflow.
        w_read_req = !w_full && !bus.redirect_i;
        if (bus.redirect_i) begin
          w_pc_nxt = w_redir_aligned;
        end else if (!w_full) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        w_read_req = 1'b1;
        if (bus.redirect_i) begin
          if (bus.imem_resp_i) begin
            // Response and redirect collide: the data belongs to the wrong
            // path, and the request is already closed, so restart directly.
            w_pc_nxt    = w_redir_aligned;
            w_state_nxt = S_IDLE;
          end else begin
            // The memory still owes us a response; wait it out in DROP.
            w_redir_pc_nxt = w_redir_aligned;
            w_state_nxt    = S_DROP;
          end
        end else if (bus.imem_resp_i) begin
          w_push      = 1'b1;
          w_pc_nxt    = w_next_pc;
          w_state_nxt = S_IDLE;
        end
      end

      S_DROP: begin
        w_read_req = 1'b1;
        if (bus.redirect_i) begin
          w_redir_pc_nxt = w_redir_aligned;
        end
        if (bus.imem_resp_i) begin
          // A redirect arriving with the response is newer than the saved PC.
          w_pc_nxt    = bus.redirect_i ? w_redir_aligned : r_redir_pc;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM and PC registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_redir_pc    <= '0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_redir_pc <= w_redir_pc_nxt;
      // The BTB lookup is combinational on imem_addr_o, so it is only valid
      // for this fetch at the moment of issue.
      if (w_issue) begin
        r_pred_taken  <= bus.pred_taken_i;
        r_pred_target <= bus.pred_target_i & c_addr_mask;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Queue pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.redirect_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= f_ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= f_ptr_inc(r_head);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Queue storage; contents are qualified by r_count so no reset is needed.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_tail]    <= r_pc;
      r_q_instr[r_tail] <= bus.imem_rdata_i;
      r_q_pred[r_tail]  <= r_pred_taken;
      r_q_next[r_tail]  <= w_next_pc;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The FSM sits in IDLE with an empty queue during reset, which would
  // otherwise request; the request is explicitly held low while rst is low.
  assign bus.imem_read_o      = rst && w_read_req;
  assign bus.imem_addr_o      = r_pc;

  assign bus.deq_valid_o      = (r_count != '0);
  assign bus.deq_pc_o         = r_q_pc[r_head];
  assign bus.deq_instr_o      = r_q_instr[r_head];
  assign bus.deq_pred_taken_o = r_q_pred[r_head];
  assign bus.deq_next_pc_o    = r_q_next[r_head];
  assign bus.count_o          = r_count;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_queue
//  Purpose  : Self-checking bench for if_fetch_queue. A QDEPTH=4 instance is
//             driven by a cycle table plus a mid-request reset sequence; a
//             QDEPTH=3 instance is driven randomly against a queue-based
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch_queue;

  logic clk  = 1'b0;
  logic rst4 = 1'b0;
  logic rst3 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  if_fetch_queue_if #(.XLEN(32), .QDEPTH(4)) bus4 ();
  if_fetch_queue_if #(.XLEN(32), .QDEPTH(3)) bus3 ();

  if_fetch_queue #(.XLEN(32), .QDEPTH(4), .RESET_PC(32'h0000_0060)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  if_fetch_queue #(.XLEN(32), .QDEPTH(3), .RESET_PC(32'h0000_0060)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        resp;
    logic [31:0] rdata;
    logic        pt;
    logic [31:0] ptgt;
    logic        rdy;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_pred;
    logic [31:0] e_next;
    int          e_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
    logic [31:0] next;
  } ent_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rd, input logic [31:0] rpc, input logic resp,
                     input logic [31:0] rdata, input logic pt, input logic [31:0] ptgt,
                     input logic rdy, input logic e_read, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_instr,
                     input logic e_pred, input logic [31:0] e_next, input int e_cnt);
    vec_t v;
    v = '{rd, rpc, resp, rdata, pt, ptgt, rdy, e_read, e_addr, e_valid,
          e_pc, e_instr, e_pred, e_next, e_cnt};
    vecs.push_back(v);
  endtask

  task automatic drive4(input vec_t v);
    bus4.redirect_i    = v.rd;
    bus4.redirect_pc_i = v.rpc;
    bus4.imem_resp_i   = v.resp;
    bus4.imem_rdata_i  = v.rdata;
    bus4.pred_taken_i  = v.pt;
    bus4.pred_target_i = v.ptgt;
    bus4.deq_ready_i   = v.rdy;
  endtask

  task automatic check4(input vec_t v, input int i);
    chk("read",  i, 32'(bus4.imem_read_o), 32'(v.e_read));
    chk("addr",  i, bus4.imem_addr_o, v.e_addr);
    chk("valid", i, 32'(bus4.deq_valid_o), 32'(v.e_valid));
    chk("count", i, 32'(bus4.count_o), 32'(v.e_cnt));
    if (v.e_valid) begin
      chk("deq_pc",    i, bus4.deq_pc_o, v.e_pc);
      chk("deq_instr", i, bus4.deq_instr_o, v.e_instr);
      chk("deq_pred",  i, 32'(bus4.deq_pred_taken_o), 32'(v.e_pred));
      chk("deq_next",  i, bus4.deq_next_pc_o, v.e_next);
    end
  endtask

  // --------------------------------------------------------------------------
  // Randomised run on the QDEPTH=3 instance against a queue model.
  // --------------------------------------------------------------------------
  task automatic run_random();
    ent_t        mq[$];
    ent_t        e;
    logic [31:0] m_pc    = 32'h60;
    logic        m_out   = 1'b0;   // a fetch is outstanding
    logic        m_stale = 1'b0;   // that fetch has been squashed
    logic [31:0] m_saved = '0;
    logic        m_pred  = 1'b0;
    logic [31:0] m_tgt   = '0;
    logic        busy    = 1'b0;
    int          lat     = 0;
    int          maxc    = 0;
    int          n;
    logic        rd, resp, pt, rdy, seen_read, e_read;
    logic [31:0] rpc, rdata, ptgt, r, nxt;

    @(negedge clk);
    rst3 = 1'b1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      rd    = ($urandom_range(15) == 0);
      rpc   = ($urandom_range(5) == 0) ? (32'hffff_fff0 | 32'($urandom_range(15)))
                                       : ($urandom & 32'h0000_0fff);
      pt    = ($urandom_range(5) == 0);
      ptgt  = $urandom & 32'h0000_0fff;
      // Alternate long stretches of mostly-stalled and mostly-ready ID.
      rdy   = ((cyc / 64) % 2 == 0) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      resp  = busy && (lat == 0);
      rdata = $urandom;
      bus3.redirect_i    = rd;
      bus3.redirect_pc_i = rpc;
      bus3.pred_taken_i  = pt;
      bus3.pred_target_i = ptgt;
      bus3.deq_ready_i   = rdy;
      bus3.imem_resp_i   = resp;
      bus3.imem_rdata_i  = rdata;
      #1;

      n      = mq.size();
      e_read = m_out ? 1'b1 : ((n < 3) && !rd);
      chk("r_read",  cyc, 32'(bus3.imem_read_o), 32'(e_read));
      chk("r_addr",  cyc, bus3.imem_addr_o, m_pc);
      chk("r_count", cyc, 32'(bus3.count_o), 32'(n));
      chk("r_valid", cyc, 32'(bus3.deq_valid_o), 32'(n != 0));
      if (n != 0) begin
        chk("r_deq_pc",    cyc, bus3.deq_pc_o, mq[0].pc);
        chk("r_deq_instr", cyc, bus3.deq_instr_o, mq[0].instr);
        chk("r_deq_pred",  cyc, 32'(bus3.deq_pred_taken_o), 32'(mq[0].pred));
        chk("r_deq_next",  cyc, bus3.deq_next_pc_o, mq[0].next);
      end
      if (int'(bus3.count_o) > maxc) maxc = int'(bus3.count_o);
      seen_read = bus3.imem_read_o;

      // Reference model: effect of the coming clock edge.
      if (rd) begin
        r = rpc & ~32'h3;
        mq.delete();
        if (!m_out) begin
          m_pc = r;
        end else if (resp) begin
          m_out = 1'b0; m_stale = 1'b0; m_pc = r;
        end else begin
          m_stale = 1'b1; m_saved = r;
        end
      end else begin
        if (rdy && n > 0) void'(mq.pop_front());
        if (m_out && resp) begin
          if (m_stale) begin
            m_pc = m_saved;
          end else begin
            nxt = m_pred ? m_tgt : m_pc + 32'd4;
            e   = '{m_pc, rdata, m_pred, nxt};
            mq.push_back(e);
            m_pc = nxt;
          end
          m_out = 1'b0; m_stale = 1'b0;
        end else if (!m_out && n < 3) begin
          m_out = 1'b1; m_pred = pt; m_tgt = ptgt & ~32'h3;
        end
      end

      // Memory: accepts a request when idle, answers after 0..2 extra cycles.
      if (resp)           busy = 1'b0;
      else if (busy)      lat--;
      else if (seen_read) begin busy = 1'b1; lat = $urandom_range(2); end

      @(negedge clk);
    end
    chk("r_max_count_le3", 0, 32'(maxc <= 3), 32'd1);
  endtask

  initial begin
    bus4.redirect_i = 0; bus4.redirect_pc_i = 0; bus4.imem_resp_i = 0;
    bus4.imem_rdata_i = 0; bus4.pred_taken_i = 0; bus4.pred_target_i = 0;
    bus4.deq_ready_i = 0;
    bus3.redirect_i = 0; bus3.redirect_pc_i = 0; bus3.imem_resp_i = 0;
    bus3.imem_rdata_i = 0; bus3.pred_taken_i = 0; bus3.pred_target_i = 0;
    bus3.deq_ready_i = 0;

    //  rd rpc          rsp rdata          pt ptgt    rdy | read addr          v pc            instr          pr next         cnt
    add(0, 0,            0, 0,             0, 0,       0,   1, 32'h60,        0, 0,            0,             0, 0,            0);
    add(0, 0,            1, 32'h13,        0, 0,       0,   1, 32'h60,        0, 0,            0,             0, 0,            0);
    add(0, 0,            0, 0,             1, 32'h102, 0,   1, 32'h64,        1, 32'h60,       32'h13,        0, 32'h64,       1);
    add(0, 0,            1, 32'h1111_1111, 0, 0,       0,   1, 32'h64,        1, 32'h60,       32'h13,        0, 32'h64,       1);
    add(0, 0,            0, 0,             0, 0,       0,   1, 32'h100,       1, 32'h60,       32'h13,        0, 32'h64,       2);
    add(0, 0,            1, 32'h22,        0, 0,       0,   1, 32'h100,       1, 32'h60,       32'h13,        0, 32'h64,       2);
    add(0, 0,            0, 0,             0, 0,       0,   1, 32'h104,       1, 32'h60,       32'h13,        0, 32'h64,       3);
    add(0, 0,            1, 32'h33,        0, 0,       0,   1, 32'h104,       1, 32'h60,       32'h13,        0, 32'h64,       3);
    add(0, 0,            0, 0,             0, 0,       0,   0, 32'h108,       1, 32'h60,       32'h13,        0, 32'h64,       4);
    add(0, 0,            0, 0,             0, 0,       1,   0, 32'h108,       1, 32'h60,       32'h13,        0, 32'h64,       4);
    add(0, 0,            0, 0,             0, 0,       0,   1, 32'h108,       1, 32'h64,       32'h1111_1111, 1, 32'h100,      3);
    add(1, 32'h200,      0, 0,             0, 0,       0,   1, 32'h108,       1, 32'h64,       32'h1111_1111, 1, 32'h100,      3);
    add(0, 0,            0, 0,             0, 0,       0,   1, 32'h108,       0, 0,            0,             0, 0,            0);
    add(0, 0,            1, 32'hdead_beef, 0, 0,       0,   1, 32'h108,       0, 0,            0,             0, 0,            0);
    add(0, 0,            0, 0,             0, 0,       0,   1, 32'h200,       0, 0,            0,             0, 0,            0);
    add(0, 0,            1, 32'h44,        0, 0,       0,   1, 32'h200,       0, 0,            0,             0, 0,            0);
    add(0, 0,            0, 0,             0, 0,       0,   1, 32'h204,       1, 32'h200,      32'h44,        0, 32'h204,      1);
    add(0, 0,            1, 32'h55,        0, 0,       0,   1, 32'h204,       1, 32'h200,      32'h44,        0, 32'h204,      1);
    add(0, 0,            0, 0,             0, 0,       0,   1, 32'h208,       1, 32'h200,      32'h44,        0, 32'h204,      2);
    add(1, 32'h300,      1, 32'h66,        0, 0,       1,   1, 32'h208,       1, 32'h200,      32'h44,        0, 32'h204,      2);
    add(0, 0,            0, 0,             0, 0,       0,   1, 32'h300,       0, 0,            0,             0, 0,            0);
    add(1, 32'h3f0,      0, 0,             0, 0,       0,   1, 32'h300,       0, 0,            0,             0, 0,            0);
    add(1, 32'h400,      1, 32'h5a5a,      0, 0,       0,   1, 32'h300,       0, 0,            0,             0, 0,            0);
    add(1, 32'hffff_ffff,0, 0,             0, 0,       0,   0, 32'h400,       0, 0,            0,             0, 0,            0);
    add(0, 0,            0, 0,             0, 0,       0,   1, 32'hffff_fffc, 0, 0,            0,             0, 0,            0);
    add(0, 0,            1, 32'h77,        0, 0,       0,   1, 32'hffff_fffc, 0, 0,            0,             0, 0,            0);
    add(0, 0,            0, 0,             0, 0,       1,   1, 32'h0,         1, 32'hffff_fffc,32'h77,        0, 32'h0,        1);
    add(0, 0,            1, 32'h88,        0, 0,       1,   1, 32'h0,         0, 0,            0,             0, 0,            0);
    add(0, 0,            0, 0,             0, 0,       1,   1, 32'h4,         1, 32'h0,        32'h88,        0, 32'h4,        1);
    add(0, 0,            1, 32'h99,        0, 0,       1,   1, 32'h4,         0, 0,            0,             0, 0,            0);
    add(0, 0,            0, 0,             0, 0,       0,   1, 32'h8,         1, 32'h4,        32'h99,        0, 32'h8,        1);
    add(0, 0,            1, 32'haa,        0, 0,       1,   1, 32'h8,         1, 32'h4,        32'h99,        0, 32'h8,        1);
    add(0, 0,            0, 0,             0, 0,       0,   1, 32'hc,         1, 32'h8,        32'haa,        0, 32'hc,        1);

    // While reset is held the queue is idle and empty, yet must not request.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_read",  0, 32'(bus4.imem_read_o), 32'd0);
    chk("rst_valid", 0, 32'(bus4.deq_valid_o), 32'd0);
    chk("rst_count", 0, 32'(bus4.count_o), 32'd0);
    chk("rst_addr",  0, bus4.imem_addr_o, 32'h60);

    @(negedge clk);
    rst4 = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive4(vecs[i]);
      #1;
      check4(vecs[i], i);
      @(negedge clk);
    end

    // The last vector issued a fetch at 0xC; reset now lands mid-request.
    drive4('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    #2;
    rst4 = 1'b0;
    #1;
    chk("midreq_rst_read",  1, 32'(bus4.imem_read_o), 32'd0);
    chk("midreq_rst_addr",  1, bus4.imem_addr_o, 32'h60);
    chk("midreq_rst_count", 1, 32'(bus4.count_o), 32'd0);
    @(negedge clk);
    rst4 = 1'b1;
    #1;
    chk("midreq_rel_read", 2, 32'(bus4.imem_read_o), 32'd1);
    chk("midreq_rel_addr", 2, bus4.imem_addr_o, 32'h60);
    @(negedge clk);
    bus4.imem_resp_i  = 1'b1;
    bus4.imem_rdata_i = 32'h0000_0013;
    @(negedge clk);
    bus4.imem_resp_i  = 1'b0;
    #1;
    chk("midreq_fetch_pc",   3, bus4.deq_pc_o, 32'h60);
    chk("midreq_fetch_next", 3, bus4.deq_next_pc_o, 32'h64);
    chk("midreq_fetch_addr", 3, bus4.imem_addr_o, 32'h64);

    run_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
